// File: rtl/mul_arb_pkg.sv
// Shared types and default widths for the multiplier arbiter and its helpers.
package mul_arb_pkg;

   localparam int NR_OF_MASTERS_DEF  = 4;
   localparam int AXI_DATA_WIDTH_DEF = 32;
   localparam int AXI_ID_WIDTH_DEF   = 4;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_FORWARD = 2'd1,
      ARB_WAIT    = 2'd2
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request after last_grant_i, wrapping.
// Zero latency; found_o low when no request is pending.
module rr_priority_select
   import mul_arb_pkg::*;
#(
   parameter int N_P = 4,
   localparam int IDX_W = idx_width(N_P)
) (
   input  logic [N_P-1:0]   req_i,
   input  logic [IDX_W-1:0] last_grant_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest offset down so the nearest requester is assigned last and wins.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      cand    = '0;
      for (int i = N_P; i >= 1; i--) begin
         cand = IDX_W'((int'(last_grant_i) + i) % N_P);
         if (req_i[cand]) begin
            idx_o   = cand;
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_axi4s_rr_arbiter.sv
// Round-robin share of one AXI4-S multiplier; 1-cycle grant, result 1 cycle after mul_rsp_tvalid.
// Granted requester sees mul_tready directly; optional result watchdog under MUL_ARB_TIMEOUT_EN.
module mul_axi4s_rr_arbiter
   import mul_arb_pkg::*;
#(
   parameter int NR_OF_MASTERS_P  = NR_OF_MASTERS_DEF,
   parameter int AXI_DATA_WIDTH_P = AXI_DATA_WIDTH_DEF,
   parameter int AXI_ID_WIDTH_P   = AXI_ID_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES_P = TIMEOUT_CYCLES_DEF
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [NR_OF_MASTERS_P-1:0]                 req_tvalid_i,
   output logic [NR_OF_MASTERS_P-1:0]                 req_tready_o,
   input  logic [NR_OF_MASTERS_P*AXI_DATA_WIDTH_P-1:0] req_tdata_i,
   input  logic [NR_OF_MASTERS_P-1:0]                 req_tlast_i,
   input  logic [NR_OF_MASTERS_P*AXI_ID_WIDTH_P-1:0]   req_tid_i,
   output logic [NR_OF_MASTERS_P-1:0]                 rsp_tvalid_o,
   output logic [AXI_DATA_WIDTH_P-1:0]                rsp_tdata_o,
   output logic                                       rsp_tlast_o,
   output logic [AXI_ID_WIDTH_P-1:0]                  rsp_tid_o,
   output logic                                       rsp_tuser_o,
   output logic                                       mul_tvalid_o,
   input  logic                                       mul_tready_i,
   output logic [AXI_DATA_WIDTH_P-1:0]                mul_tdata_o,
   output logic                                       mul_tlast_o,
   output logic [AXI_ID_WIDTH_P-1:0]                  mul_tid_o,
   input  logic                                       mul_rsp_tvalid_i,
   input  logic [AXI_DATA_WIDTH_P-1:0]                mul_rsp_tdata_i,
   input  logic                                       mul_rsp_tuser_i
);

   localparam int IDX_W = idx_width(NR_OF_MASTERS_P);

   arb_state_t                   state_q;
   logic [IDX_W-1:0]             grant_q;
   logic [IDX_W-1:0]             last_grant_q;
   logic [AXI_ID_WIDTH_P-1:0]    tid_q;
   logic [NR_OF_MASTERS_P-1:0]   rsp_tvalid_q;
   logic [AXI_DATA_WIDTH_P-1:0]  rsp_tdata_q;
   logic                         rsp_tlast_q;
   logic [AXI_ID_WIDTH_P-1:0]    rsp_tid_q;
   logic                         rsp_tuser_q;
   logic [IDX_W-1:0]             sel_idx;
   logic                         sel_found;
   logic                         last_hs;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES_P + 1);
   logic [CNT_W-1:0] cnt_q;
`endif

   rr_priority_select #(.N_P(NR_OF_MASTERS_P)) u_sel (
      .req_i        (req_tvalid_i),
      .last_grant_i (last_grant_q),
      .idx_o        (sel_idx),
      .found_o      (sel_found)
   );

   always_comb begin
      mul_tvalid_o = 1'b0;
      mul_tdata_o  = '0;
      mul_tlast_o  = 1'b0;
      mul_tid_o    = '0;
      req_tready_o = '0;
      if (state_q == ARB_FORWARD) begin
         mul_tvalid_o          = req_tvalid_i[grant_q];
         mul_tdata_o           = req_tdata_i[int'(grant_q)*AXI_DATA_WIDTH_P +: AXI_DATA_WIDTH_P];
         mul_tlast_o           = req_tlast_i[grant_q];
         mul_tid_o             = req_tid_i[int'(grant_q)*AXI_ID_WIDTH_P +: AXI_ID_WIDTH_P];
         req_tready_o[grant_q] = mul_tready_i;
      end
   end

   assign last_hs = mul_tvalid_o & mul_tready_i & mul_tlast_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NR_OF_MASTERS_P - 1);
         tid_q        <= '0;
         rsp_tvalid_q <= '0;
         rsp_tdata_q  <= '0;
         rsp_tlast_q  <= 1'b0;
         rsp_tid_q    <= '0;
         rsp_tuser_q  <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         // Response fields are single-cycle pulses; idle back to zero.
         rsp_tvalid_q <= '0;
         rsp_tdata_q  <= '0;
         rsp_tlast_q  <= 1'b0;
         rsp_tid_q    <= '0;
         rsp_tuser_q  <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (sel_found) begin
                  grant_q      <= sel_idx;
                  last_grant_q <= sel_idx;
                  state_q      <= ARB_FORWARD;
               end
            end
            ARB_FORWARD: begin
               if (last_hs) begin
                  tid_q   <= mul_tid_o;
                  state_q <= ARB_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            ARB_WAIT: begin
               if (mul_rsp_tvalid_i) begin
                  rsp_tvalid_q[grant_q] <= 1'b1;
                  rsp_tdata_q           <= mul_rsp_tdata_i;
                  rsp_tuser_q           <= mul_rsp_tuser_i;
                  rsp_tid_q             <= tid_q;
                  rsp_tlast_q           <= 1'b1;
                  state_q               <= ARB_IDLE;
               end
`ifdef MUL_ARB_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT_CYCLES_P - 1)) begin
                  rsp_tvalid_q[grant_q] <= 1'b1;
                  rsp_tuser_q           <= 1'b1;
                  rsp_tid_q             <= tid_q;
                  rsp_tlast_q           <= 1'b1;
                  state_q               <= ARB_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign rsp_tvalid_o = rsp_tvalid_q;
   assign rsp_tdata_o  = rsp_tdata_q;
   assign rsp_tlast_o  = rsp_tlast_q;
   assign rsp_tid_o    = rsp_tid_q;
   assign rsp_tuser_o  = rsp_tuser_q;

endmodule

// File: tb/tb_mul_axi4s_rr_arbiter.sv
// Bench for mul_axi4s_rr_arbiter: queue-based requesters, Q16 multiplier model, rotation scoreboard.
module tb_mul_axi4s_rr_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_tvalid, req_tready, req_tlast, rsp_tvalid;
   logic [NR*DW-1:0] req_tdata;
   logic [NR*IW-1:0] req_tid;
   logic [DW-1:0]    rsp_tdata, mul_tdata, mul_rsp_tdata;
   logic             rsp_tlast, rsp_tuser, mul_tvalid, mul_tready, mul_tlast;
   logic             mul_rsp_tvalid, mul_rsp_tuser;
   logic [IW-1:0]    rsp_tid, mul_tid;

   mul_axi4s_rr_arbiter #(
      .NR_OF_MASTERS_P(NR), .AXI_DATA_WIDTH_P(DW), .AXI_ID_WIDTH_P(IW), .TIMEOUT_CYCLES_P(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_tvalid_i(req_tvalid), .req_tready_o(req_tready), .req_tdata_i(req_tdata),
      .req_tlast_i(req_tlast), .req_tid_i(req_tid),
      .rsp_tvalid_o(rsp_tvalid), .rsp_tdata_o(rsp_tdata), .rsp_tlast_o(rsp_tlast),
      .rsp_tid_o(rsp_tid), .rsp_tuser_o(rsp_tuser),
      .mul_tvalid_o(mul_tvalid), .mul_tready_i(mul_tready), .mul_tdata_o(mul_tdata),
      .mul_tlast_o(mul_tlast), .mul_tid_o(mul_tid),
      .mul_rsp_tvalid_i(mul_rsp_tvalid), .mul_rsp_tdata_i(mul_rsp_tdata), .mul_rsp_tuser_i(mul_rsp_tuser)
   );

   typedef struct { logic [DW-1:0] d; logic l; logic [IW-1:0] id; } beat_t;
   typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic [IW-1:0] id; } pkt_t;
   typedef struct { int r; logic [DW-1:0] a; logic [DW-1:0] b; logic [IW-1:0] id;
                    logic [DW-1:0] exp_d; logic exp_u; } vec_t;

   beat_t src_q[NR][$];
   pkt_t  mdl_q[NR][$];
   int    order_q[$];
   vec_t  vecs[5];

   int n_checks = 0, n_fail = 0, cyc = 0;
   int mdl_last = NR - 1;
   int mul_lat = 2, rx_count = 0, rsp_seen = 0, rsp_cyc = 0, mrsp_cyc = 0;
   logic mute = 1'b0, to_mode = 1'b0;
   int last_r;
   logic [DW-1:0] last_d;
   logic last_u;
   logic [IW-1:0] last_id;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Signed Q16.16 product with saturation; bit DW is the overflow flag.
   function automatic logic [DW:0] q16mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [63:0] sa, sb, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = (sa * sb) >>> 16;
      if (p > 64'sh7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
      if (p < -64'sh8000_0000) return {1'b1, 32'h8000_0000};
      return {1'b0, p[31:0]};
   endfunction

   function automatic int pending();
      int s = 0;
      for (int r = 0; r < NR; r++) s += mdl_q[r].size();
      return s;
   endfunction

   task automatic push_pkt(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [IW-1:0] id);
      beat_t b0, b1;
      pkt_t  p;
      b0.d = a; b0.l = 1'b0; b0.id = id;
      b1.d = b; b1.l = 1'b1; b1.id = id;
      p.a = a; p.b = b; p.id = id;
      src_q[r].push_back(b0);
      src_q[r].push_back(b1);
      mdl_q[r].push_back(p);
   endtask

   task automatic drain(input string name);
      int budget = 3000;
      while (pending() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check(name, 64'(pending()), 64'd0);
      if (pending() > 0)
         for (int r = 0; r < NR; r++) begin
            mdl_q[r].delete();
            src_q[r].delete();
         end
      repeat (2) @(negedge clk);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Requesters: each presents the head of its beat queue until handshaken.
   initial begin
      logic [NR-1:0] hs;
      req_tvalid = '0; req_tdata = '0; req_tlast = '0; req_tid = '0;
      forever begin
         @(negedge clk);
         hs = req_tvalid & req_tready;
         @(posedge clk);
         #1;
         for (int r = 0; r < NR; r++) begin
            if (hs[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
            if (src_q[r].size() > 0) begin
               req_tvalid[r]           = 1'b1;
               req_tdata[r*DW +: DW]   = src_q[r][0].d;
               req_tlast[r]            = src_q[r][0].l;
               req_tid[r*IW +: IW]     = src_q[r][0].id;
            end else begin
               req_tvalid[r] = 1'b0;
               req_tlast[r]  = 1'b0;
            end
         end
      end
   end

   // Shared multiplier: collects two beats, answers after mul_lat cycles unless muted.
   initial begin
      logic mhs, ml, pend;
      logic [DW-1:0] md, opa;
      logic [DW:0] res;
      int cnt;
      pend = 1'b0; cnt = 0; opa = '0; res = '0;
      mul_rsp_tvalid = 1'b0; mul_rsp_tdata = '0; mul_rsp_tuser = 1'b0;
      forever begin
         @(negedge clk);
         mhs = mul_tvalid & mul_tready;
         md  = mul_tdata;
         ml  = mul_tlast;
         if (mul_rsp_tvalid) mrsp_cyc = cyc;
         @(posedge clk);
         #1;
         mul_rsp_tvalid = 1'b0;
         if (pend) begin
            if (cnt == 0) begin
               mul_rsp_tvalid = 1'b1;
               mul_rsp_tdata  = res[DW-1:0];
               mul_rsp_tuser  = res[DW];
               pend = 1'b0;
            end else cnt--;
         end
         if (mhs) begin
            if (!ml) opa = md;
            else begin
               rx_count++;
               if (!mute) begin
                  res  = q16mul(opa, md);
                  pend = 1'b1;
                  cnt  = mul_lat;
               end
            end
         end
      end
   end

   // Scoreboard: each result must go to the next requester in rotation that still has work.
   initial forever begin
      int er;
      pkt_t p;
      logic [DW:0] exp;
      @(negedge clk);
      if (|rsp_tvalid) begin
         rsp_seen++;
         rsp_cyc = cyc;
         er = -1;
         for (int k = 1; k <= NR; k++)
            if (er < 0 && mdl_q[(mdl_last + k) % NR].size() > 0) er = (mdl_last + k) % NR;
         if (er < 0) check("unexpected_rsp", 64'(rsp_tvalid), 64'd0);
         else begin
            p = mdl_q[er].pop_front();
            mdl_last = er;
            order_q.push_back(er);
            exp = to_mode ? {1'b1, {DW{1'b0}}} : q16mul(p.a, p.b);
            check("rsp_onehot", 64'(rsp_tvalid), 64'(1 << er));
            check("rsp_tdata", 64'(rsp_tdata), 64'(exp[DW-1:0]));
            check("rsp_tuser", 64'(rsp_tuser), 64'(exp[DW]));
            check("rsp_tid", 64'(rsp_tid), 64'(p.id));
            check("rsp_tlast", 64'(rsp_tlast), 64'd1);
            last_r = er; last_d = rsp_tdata; last_u = rsp_tuser; last_id = rsp_tid;
         end
      end
   end

   initial begin
      int start, base, budget, nrx;
      vecs[0] = '{0, 32'h0002_0000, 32'h0003_0000, 4'd5,  32'h0006_0000, 1'b0};
      vecs[1] = '{2, 32'h7FFF_0000, 32'h7FFF_0000, 4'd3,  32'h7FFF_FFFF, 1'b1};
      vecs[2] = '{1, 32'h0000_8000, 32'h0004_0000, 4'd9,  32'h0002_0000, 1'b0};
      vecs[3] = '{3, 32'hFFFF_0000, 32'h0005_0000, 4'hA,  32'hFFFB_0000, 1'b0};
      vecs[4] = '{0, 32'hFFFE_0000, 32'hFFFD_0000, 4'hF,  32'h0006_0000, 1'b0};

      mul_tready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
      check("reset_rsp_tdata", 64'(rsp_tdata), 64'd0);
      check("reset_rsp_tid", 64'(rsp_tid), 64'd0);
      check("reset_rsp_tuser", 64'(rsp_tuser), 64'd0);
      check("reset_rsp_tlast", 64'(rsp_tlast), 64'd0);
      check("reset_req_tready", 64'(req_tready), 64'd0);
      check("reset_mul_tvalid", 64'(mul_tvalid), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Grant latency: request visible in IDLE, ready one cycle later.
      push_pkt(0, 32'h0002_0000, 32'h0003_0000, 4'd5);
      @(negedge clk);
      check("idle_ready_low", 64'(req_tready), 64'd0);
      @(negedge clk);
      check("grant_latency", 64'(req_tready), 64'b0001);
      drain("drain_first");
      check("rsp_latency", 64'(rsp_cyc - mrsp_cyc), 64'd1);
      check("first_rsp_data", 64'(last_d), 64'h0006_0000);

      foreach (vecs[i]) begin
         push_pkt(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].id);
         drain("drain_vec");
         check("vec_req", 64'(last_r), 64'(vecs[i].r));
         check("vec_data", 64'(last_d), 64'(vecs[i].exp_d));
         check("vec_tuser", 64'(last_u), 64'(vecs[i].exp_u));
         check("vec_tid", 64'(last_id), 64'(vecs[i].id));
      end

      // Four requesters with three packets each: strict rotation.
      order_q.delete();
      start = (mdl_last + 1) % NR;
      for (int k = 0; k < 3; k++)
         for (int r = 0; r < NR; r++)
            push_pkt(r, 32'($urandom_range(0, 32'h0004_0000)), 32'($urandom_range(0, 32'h0004_0000)),
                     IW'(r * 3 + k));
      drain("drain_rr");
      check("rr_count", 64'(order_q.size()), 64'(3 * NR));
      for (int i = 0; i < order_q.size(); i++)
         check("rr_order", 64'(order_q[i]), 64'((start + i) % NR));

      // Back-pressure from the multiplier while forwarding.
      @(posedge clk); #2 mul_tready = 1'b0;
      push_pkt(2, 32'h0001_8000, 32'h0002_0000, 4'd7);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_ready_low", 64'(req_tready), 64'd0);
         check("bp_mul_valid", 64'(mul_tvalid), 64'd1);
      end
      @(posedge clk); #2 mul_tready = 1'b1;
      drain("drain_bp");
      check("bp_data", 64'(last_d), 64'h0003_0000);
      check("bp_req", 64'(last_r), 64'd2);

      // Reset while waiting for the result; the late result must vanish.
      mul_lat = 6;
      nrx = rx_count;
      push_pkt(1, 32'h0002_0000, 32'h0002_0000, 4'd2);
      budget = 200;
      while (rx_count == nrx && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("rst_pkt_sent", 64'(rx_count - nrx), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      mdl_q[1].delete();
      mdl_last = NR - 1;
      base = rsp_seen;
      @(negedge clk);
      check("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
      check("rst_req_tready", 64'(req_tready), 64'd0);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("no_late_rsp", 64'(rsp_seen - base), 64'd0);
      mul_lat = 2;
      order_q.delete();
      push_pkt(1, 32'h0001_0000, 32'h0003_0000, 4'd1);
      push_pkt(0, 32'h0001_0000, 32'h0004_0000, 4'd0);
      drain("drain_after_rst");
      check("post_rst_first", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'd0);

      // Randomized rounds against the rotation scoreboard.
      for (int round = 0; round < 8; round++) begin
         mul_lat = $urandom_range(0, 4);
         for (int r = 0; r < NR; r++)
            for (int k = $urandom_range(0, 3); k > 0; k--)
               push_pkt(r, $urandom, $urandom, IW'($urandom));
         drain("drain_rand");
      end

`ifdef MUL_ARB_TIMEOUT_EN
      mute = 1'b1;
      to_mode = 1'b1;
      push_pkt(3, 32'h0001_0000, 32'h0001_0000, 4'd6);
      drain("drain_timeout");
      check("to_data", 64'(last_d), 64'd0);
      check("to_tuser", 64'(last_u), 64'd1);
      check("to_req", 64'(last_r), 64'd3);
      mute = 1'b0;
      to_mode = 1'b0;
      mul_lat = 1;
      push_pkt(0, 32'h0002_0000, 32'h0002_0000, 4'd4);
      drain("drain_after_to");
      check("after_to_data", 64'(last_d), 64'h0004_0000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
